// File: rtl/conv_frame_scheduler.sv
// Walks each channel plane of a job through the 3x3 line-buffer engine, counts its outputs, flags errors.
// Latency: start -> sof_out 1 cycle, first rd_en 2 cycles; done 2 cycles after the last counted output.
// Backpressure: stall freezes RAM reads (address held) in STREAM only; other states ignore it.
module conv_frame_scheduler #(
    parameter int INPUT_Y  = 3,
    parameter int INPUT_X  = 3,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              sof_out,
    output logic              pix_valid,
    input  logic              conv_out_valid,
    output logic [7:0]        ch_idx,
    output logic              out_first_ch,
    output logic              out_last_ch,
    output logic              ready,
    output logic              done,
    output logic              err_timeout,
    output logic              err_overrun
);
    localparam int N     = INPUT_X * INPUT_Y;
    localparam int CNT_W = $clog2(N + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  N_C     = CNT_W'(N);
    localparam logic [CNT_W-1:0]  N_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]   TO_C    = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_ONE  = TO_W'(1);
    localparam logic [7:0]        CH_LAST = 8'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] N_A     = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  out_cnt, out_cnt_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic              to_phase;
    logic              counting;
    logic              overrun_hit;
    logic              to_hit;
    logic              accept;
    logic              drain_entry;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        to_hit      = 1'b0;
        counting    = (state != S_IDLE) && (state != S_SOF);
        overrun_hit = counting && conv_out_valid && (out_cnt == N_C);
        out_cnt_nxt = out_cnt;
        if (counting && conv_out_valid && (out_cnt != N_C))
            out_cnt_nxt = out_cnt + CNT_ONE;
        rd_en       = (state == S_STREAM) && !stall;

        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SOF;
                end
            end
            S_SOF:    state_nxt = S_STREAM;
            S_STREAM: begin
                if (rd_en && (rd_cnt == N_LAST))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Look ahead at this cycle's pulse so done lands two cycles after the final output.
                if (out_cnt_nxt == N_C) begin
                    state_nxt = S_NEXT;
                end else if (to_cnt == TO_C) begin
                    to_hit    = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT:   state_nxt = (ch_idx == CH_LAST) ? S_DONE : S_SOF;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase

        drain_entry = (state != S_DRAIN) && (state_nxt == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            base        <= '0;
            rd_addr     <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            to_cnt      <= '0;
            to_phase    <= 1'b0;
            ch_idx      <= '0;
            pix_valid   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            pix_valid <= rd_en;
            out_cnt   <= out_cnt_nxt;
            if (overrun_hit)
                err_overrun <= 1'b1;
            if (to_hit)
                err_timeout <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        base        <= cfg_base;
                        ch_idx      <= '0;
                        err_timeout <= 1'b0;
                        err_overrun <= 1'b0;
                    end
                end
                S_SOF: begin
                    rd_cnt  <= '0;
                    out_cnt <= '0;
                    rd_addr <= base;
                end
                S_STREAM: begin
                    if (rd_en) begin
                        rd_addr <= rd_addr + A_ONE;
                        rd_cnt  <= rd_cnt + CNT_ONE;
                    end
                end
                S_NEXT: begin
                    if (ch_idx != CH_LAST) begin
                        ch_idx <= ch_idx + 8'd1;
                        base   <= base + N_A;
                    end
                end
                default: ;
            endcase

            // Watchdog advances on every second quiet DRAIN cycle; any engine output rearms it.
            if (drain_entry || conv_out_valid) begin
                to_cnt   <= '0;
                to_phase <= 1'b0;
            end else if (state == S_DRAIN) begin
                to_phase <= ~to_phase;
                if (to_phase)
                    to_cnt <= to_cnt + TO_ONE;
            end
        end
    end

    assign sof_out      = (state == S_SOF);
    assign ready        = (state == S_IDLE);
    assign done         = (state == S_DONE);
    assign out_first_ch = (ch_idx == 8'd0);
    assign out_last_ch  = (ch_idx == CH_LAST);

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Bench for conv_frame_scheduler: directed jobs plus randomized jobs against a behavioural engine and address model.
module tb_conv_frame_scheduler;
    localparam int NY = 3;
    localparam int NX = 3;
    localparam int C  = 2;
    localparam int AW = 16;
    localparam int TO = 1024;
    localparam int N  = NX * NY;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stall;
    logic [AW-1:0] cfg_base;
    logic          conv_out_valid = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          sof_out;
    logic          pix_valid;
    logic [7:0]    ch_idx;
    logic          out_first_ch;
    logic          out_last_ch;
    logic          ready;
    logic          done;
    logic          err_timeout;
    logic          err_overrun;

    conv_frame_scheduler #(
        .INPUT_Y(NY), .INPUT_X(NX), .CHANNELS(C), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .stall(stall),
        .rd_en(rd_en), .rd_addr(rd_addr), .sof_out(sof_out), .pix_valid(pix_valid),
        .conv_out_valid(conv_out_valid), .ch_idx(ch_idx), .out_first_ch(out_first_ch),
        .out_last_ch(out_last_ch), .ready(ready), .done(done),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Observation log and engine model state (written only by the monitor).
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int sof_cyc_q[$];
    int sof_ch_q[$];
    int done_cyc_q[$];
    int pv_cyc_q[$];
    int pv_bad = 0, stall_bad = 0, tag_bad = 0, emit_total = 0, last_out_cyc = 0;
    int sof_total = 0, fr_out = 0;
    bit extra_pend = 1'b0, prev_rd = 1'b0, prev_rst = 1'b1;
    logic [3:0] pipe = 4'b0;

    // Engine behaviour knobs and job snapshots (written only by the stimulus block).
    int lat = 2, sup_frame = -1, extra_frame = -1, job_sof0 = 0;
    int rq0, sq0, dq0, pq0, pvb0, stb0, tgb0, em0, start_cyc;
    int exp_q[$];

    // Engine: one output per pixel, lat cycles after pix_valid; optional suppressed or over-long frame.
    always begin
        @(negedge clk);
        #1;
        begin
            int frame;
            bit emit, is_extra;
            frame = sof_total - job_sof0 - 1;
            if (pix_valid !== (prev_rd && !prev_rst)) pv_bad++;
            if (pix_valid) pv_cyc_q.push_back(cyc);
            if (rd_en && stall) stall_bad++;
            if (rd_en) begin
                rd_addr_q.push_back(int'(rd_addr));
                rd_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);

            emit     = pipe[lat-1];
            is_extra = 1'b0;
            if (extra_pend) begin
                emit       = 1'b1;
                is_extra   = 1'b1;
                extra_pend = 1'b0;
            end
            if (emit && !is_extra && frame == sup_frame) emit = 1'b0;
            if (emit) begin
                emit_total++;
                if (out_first_ch !== (frame == 0) || out_last_ch !== (frame == C - 1)) tag_bad++;
                if (!is_extra) begin
                    last_out_cyc = cyc;
                    fr_out++;
                    if (frame == extra_frame && fr_out == N) extra_pend = 1'b1;
                end
            end
            conv_out_valid = emit;
            pipe = {pipe[2:0], pix_valid};

            if (sof_out) begin
                sof_cyc_q.push_back(cyc);
                sof_ch_q.push_back(int'(ch_idx));
                sof_total++;
                fr_out = 0;
            end
            prev_rd  = rd_en;
            prev_rst = rst;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int base);
        @(negedge clk);
        rq0 = rd_addr_q.size();  sq0 = sof_cyc_q.size(); dq0 = done_cyc_q.size();
        pq0 = pv_cyc_q.size();   pvb0 = pv_bad;          stb0 = stall_bad;
        tgb0 = tag_bad;          em0 = emit_total;       job_sof0 = sof_total;
        cfg_base  = AW'(base);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_stall);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        stall = 1'b0;
        check("done_within_budget", got, 1);
        tick(6);
    endtask

    // Expected addresses: channel base advances by a plane, x outer, y inner, modulo 2^AW.
    task automatic check_job(input string tag, input int base, input int exp_done);
        int bad = 0;
        exp_q.delete();
        for (int c = 0; c < C; c++)
            for (int x = 0; x < NX; x++)
                for (int y = 0; y < NY; y++)
                    exp_q.push_back((base + c * N + x * NY + y) % (1 << AW));
        check({tag, "_rd_count"}, rd_addr_q.size() - rq0, exp_q.size());
        for (int i = 0; i < exp_q.size() && rq0 + i < rd_addr_q.size(); i++)
            if (rd_addr_q[rq0 + i] != exp_q[i]) bad++;
        check({tag, "_rd_addr_seq"}, bad, 0);
        check({tag, "_sof_count"}, sof_cyc_q.size() - sq0, C);
        for (int c = 0; c < C; c++)
            check({tag, "_sof_ch_idx"}, (sq0 + c < sof_ch_q.size()) ? sof_ch_q[sq0 + c] : -1, c);
        check({tag, "_done_count"}, done_cyc_q.size() - dq0, exp_done);
        check({tag, "_pix_valid_mirror"}, pv_bad - pvb0, 0);
        check({tag, "_rd_while_stalled"}, stall_bad - stb0, 0);
        check({tag, "_out_ch_tags"}, tag_bad - tgb0, 0);
    endtask

    initial begin
        int gap;
        bit got;
        rst = 1'b1; start = 1'b0; stall = 1'b0; cfg_base = '0;
        tick(3);
        check("rst_ready", ready, 1);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_sof", sof_out, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_ch_idx", ch_idx, 0);
        check("rst_done", done, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_first_ch", out_first_ch, 1);
        check("rst_last_ch", out_last_ch, 0);
        rst = 1'b0;
        tick(2);

        // Basic two-channel job at 0x100.
        lat = 2;
        do_start(32'h100);
        wait_done(400, 1'b0);
        check_job("basic", 32'h100, 1);
        check("lat_sof", sof_cyc_q[sq0] - start_cyc, 1);
        check("lat_first_rd", rd_cyc_q[rq0] - start_cyc, 2);
        check("lat_first_pv", pv_cyc_q[pq0] - start_cyc, 3);
        check("stream_contiguous", rd_cyc_q[rq0 + N - 1] - rd_cyc_q[rq0], N - 1);
        gap = sof_cyc_q[sq0 + 1] - sof_cyc_q[sq0];
        check("sof_gap_min", gap >= N + 3, 1);
        check("done_after_last_out", done_cyc_q[dq0] - last_out_cyc, 2);
        check("basic_err_timeout", err_timeout, 0);
        check("basic_err_overrun", err_overrun, 0);
        check("basic_ready_end", ready, 1);

        // Three-cycle stall right after the fourth read.
        do_start(32'h100);
        while (cyc < start_cyc + 6) @(negedge clk);
        stall = 1'b1;
        tick(1);
        check("stall_addr_hold", rd_addr, 32'h104);
        check("stall_rd_en", rd_en, 0);
        tick(2);
        stall = 1'b0;
        wait_done(400, 1'b0);
        check_job("stall", 32'h100, 1);
        check("stall_rd_gap", rd_cyc_q[rq0 + 4] - rd_cyc_q[rq0 + 3], 4);
        check("stall_resume_addr", rd_addr_q[rq0 + 4], 32'h104);
        gap = 0;
        for (int i = rq0; i < rd_cyc_q.size(); i++)
            if (rd_cyc_q[i] < sof_cyc_q[sq0 + 1]) gap++;
        check("stall_ch0_reads", gap, N);

        // Channel 0 produces nothing: watchdog abandons it, channel 1 still runs.
        sup_frame = 0;
        do_start(32'h100);
        wait_done(6000, 1'b0);
        sup_frame = -1;
        check_job("timeout", 32'h100, 1);
        check("timeout_err", err_timeout, 1);
        check("timeout_no_overrun", err_overrun, 0);
        gap = sof_cyc_q[sq0 + 1] - rd_cyc_q[rq0 + N - 1];
        check("timeout_duration", (gap >= 2 * TO) && (gap <= 2 * TO + 6), 1);

        // One extra output on channel 0: overrun flagged, job completes.
        extra_frame = 0;
        do_start(32'h100);
        wait_done(400, 1'b0);
        extra_frame = -1;
        check_job("overrun", 32'h100, 1);
        check("overrun_err", err_overrun, 1);
        check("overrun_no_timeout", err_timeout, 0);
        check("overrun_pulses", emit_total - em0, 2 * N + 1);

        // Restart ignored mid-stream; reset during the last channel's drain aborts cleanly.
        extra_frame = 0;
        sup_frame = 1;
        do_start(32'h100);
        check("start_clears_err", err_overrun, 0);
        tick(2);
        cfg_base = 16'h0500;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd_addr_q.size() - rq0 >= C * N) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_reads_reached", got, 1);
        tick(20);
        check("abort_mid_job_busy", ready, 0);
        check("abort_overrun_before_rst", err_overrun, 1);
        rst = 1'b1;
        tick(1);
        check("abort_ready", ready, 1);
        check("abort_rd_en", rd_en, 0);
        check("abort_pix_valid", pix_valid, 0);
        check("abort_err_overrun", err_overrun, 0);
        check("abort_err_timeout", err_timeout, 0);
        check("abort_ch_idx", ch_idx, 0);
        rst = 1'b0;
        tick(40);
        check_job("abort", 32'h100, 0);
        extra_frame = -1;
        sup_frame = -1;

        // Address wrap at the top of the map.
        lat = 1;
        do_start(32'hFFFC);
        wait_done(400, 1'b0);
        check_job("wrap", 32'hFFFC, 1);
        check("wrap_first_addr", rd_addr_q[rq0], 32'hFFFC);
        check("wrap_err_timeout", err_timeout, 0);
        check("wrap_err_overrun", err_overrun, 0);

        // Randomized jobs: random base, engine latency and stall pattern.
        for (int j = 0; j < 6; j++) begin
            int b;
            b = int'($urandom_range(0, 65535));
            lat = int'($urandom_range(1, 3));
            do_start(b);
            wait_done(1500, 1'b1);
            check_job("rand", b, 1);
            check("rand_done_after_last_out", done_cyc_q[dq0] - last_out_cyc, 2);
            check("rand_err_timeout", err_timeout, 0);
            check("rand_err_overrun", err_overrun, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
